// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // The low op bit distinguishes the unsigned variants.
    function automatic logic is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // The high op bit selects divide over multiply.
    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative engine on unsigned magnitudes.
// Multiply: acc = {partial product, remaining multiplier bits}; shift-add.
// Divide:   acc = {remainder, dividend bits / quotient bits}; restoring.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               div_mode_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Both datapaths are evaluated; mode picks which one advances the accumulator.
    // The trial difference keeps one extra bit so its MSB is the subtract borrow
    // (the shifted remainder is always below twice the divisor, so it fits).
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, operand_i};
        acc_o  = {sum, acc_i[WIDTH-1:1]};
        if (div_mode_i) begin
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer with the HI/LO register pair.
// Works on magnitudes and applies signs in a final fix-up cycle.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     rs_q;
    logic [WIDTH-1:0]     rt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     opnd_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;

    logic                 signed_op;
    logic                 div_op;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    logic [WIDTH-1:0]     hi_fix;
    logic [WIDTH-1:0]     lo_fix;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc_i      (acc_q),
        .operand_i  (opnd_q),
        .div_mode_i (div_op),
        .acc_o      (acc_d)
    );

    // Operand magnitudes taken from the operands latched at start.
    always_comb begin
        signed_op = is_signed(op_q);
        div_op    = is_div(op_q);
        rs_mag    = (signed_op && rs_q[WIDTH-1]) ? -rs_q : rs_q;
        rt_mag    = (signed_op && rt_q[WIDTH-1]) ? -rt_q : rt_q;
    end

    // Sign fix-up: product negated as a whole; quotient and remainder separately.
    always_comb begin
        {hi_fix, lo_fix} = neg_res_q ? -acc_q : acc_q;
        if (div_op) begin
            hi_fix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_fix = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end
    end

    // Control FSM, iteration counter and HI/LO registers with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q     <= 1'b0;
                    div_zero_q <= 1'b0;
                    if (mthi_i) hi_q <= wdata_i;
                    if (mtlo_i) lo_q <= wdata_i;
                    // A move in the same cycle wins; the start is dropped.
                    if (start_i && !mthi_i && !mtlo_i) begin
                        op_q    <= op_i;
                        rs_q    <= rs_val_i;
                        rt_q    <= rt_val_i;
                        busy_q  <= 1'b1;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    cnt_q <= CW'(WIDTH);
                    if (div_op) begin
                        acc_q     <= {{WIDTH{1'b0}}, rs_mag};
                        opnd_q    <= rt_mag;
                        neg_res_q <= signed_op & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                        neg_rem_q <= signed_op & rs_q[WIDTH-1];
                    end else begin
                        acc_q     <= {{WIDTH{1'b0}}, rt_mag};
                        opnd_q    <= rs_mag;
                        neg_res_q <= signed_op & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                        neg_rem_q <= 1'b0;
                    end
                    if (div_op && (rt_q == '0)) begin
                        done_q     <= 1'b1;
                        div_zero_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q     <= 1'b0;
                    div_zero_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed products/quotients, latency,
// busy handling, HI/LO moves and asynchronous reset mid-operation.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs_val_i = '0;
    logic [31:0] rt_val_i = '0;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_val_i   (rs_val_i),
        .rt_val_i   (rt_val_i),
        .mthi_i     (mthi_i),
        .mtlo_i     (mtlo_i),
        .wdata_i    (wdata_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Launch one op and follow it; cycle 1 is the cycle after the edge that samples start.
    // With inject set, a second start arrives at cycle 10 and an mthi at cycle 15.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int lat, output int nbusy,
                         output logic dz, output logic [31:0] mid_hi);
        @(negedge clk);
        op_i = o; rs_val_i = a; rt_val_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0; nbusy = 0; dz = 1'b0; mid_hi = '0;
        for (int k = 1; k <= 60; k++) begin
            if (busy_o) nbusy++;
            if (k == 20) mid_hi = hi_o;
            if (done_o) begin
                lat = k;
                dz  = div_zero_o;
                break;
            end
            if (inject) begin
                start_i = (k == 10);
                if (k == 10) begin
                    op_i = OP_MULTU; rs_val_i = 32'h1234; rt_val_i = 32'h5678;
                end
                mthi_i  = (k == 15);
                wdata_i = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        mthi_i  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          nb;
        logic        dz;
        logic [31:0] mh;
        int          cnt;

        // Reset state
        #12;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_divz", div_zero_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1 MULTU all-ones squared
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, nb, dz, mh);
        chk("t1_lat", lat, 35);
        chk("t1_busy_cycles", nb, 35);
        chk("t1_hi", hi_o, 64'hFFFF_FFFE);
        chk("t1_lo", lo_o, 64'h0000_0001);
        chk("t1_divz", dz, 0);
        @(negedge clk);
        chk("t1_done_pulse", done_o, 0);
        chk("t1_idle_busy", busy_o, 0);

        // T2 MULT -3 x 7
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, nb, dz, mh);
        chk("t2_lat", lat, 35);
        chk("t2_mid_hi_old", mh, 64'hFFFF_FFFE);
        chk("t2_hi", hi_o, 64'hFFFF_FFFF);
        chk("t2_lo", lo_o, 64'hFFFF_FFEB);

        // T3 DIV -7/2, overflow case, and 7/-2
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, nb, dz, mh);
        chk("t3a_lat", lat, 35);
        chk("t3a_lo", lo_o, 64'hFFFF_FFFD);
        chk("t3a_hi", hi_o, 64'hFFFF_FFFF);
        chk("t3a_divz", dz, 0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, nb, dz, mh);
        chk("t3b_lo", lo_o, 64'h8000_0000);
        chk("t3b_hi", hi_o, 64'h0);
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, nb, dz, mh);
        chk("t3c_lo", lo_o, 64'hFFFF_FFFD);
        chk("t3c_hi", hi_o, 64'h1);

        // Signed MIN x MIN = 2^62
        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, nb, dz, mh);
        chk("mmin_hi", hi_o, 64'h4000_0000);
        chk("mmin_lo", lo_o, 64'h0);

        // Both moves together write the same data
        @(negedge clk);
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h55;
        @(negedge clk);
        mthi_i = 1'b0; mtlo_i = 1'b0;
        chk("mv_both_hi", hi_o, 64'h55);
        chk("mv_both_lo", lo_o, 64'h55);

        // T4 DIVU by zero after separate moves
        mthi_i = 1'b1; wdata_i = 32'h11;
        @(negedge clk);
        mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = 32'h22;
        @(negedge clk);
        mtlo_i = 1'b0;
        do_op(OP_DIVU, 32'd100, 32'd0, 1'b0, lat, nb, dz, mh);
        chk("t4_lat", lat, 2);
        chk("t4_divz", dz, 1);
        chk("t4_hi", hi_o, 64'h11);
        chk("t4_lo", lo_o, 64'h22);
        @(negedge clk);
        chk("t4_divz_drop", div_zero_o, 0);

        // Move and start in the same cycle: start dropped
        mthi_i = 1'b1; wdata_i = 32'h33; start_i = 1'b1;
        op_i = OP_MULTU; rs_val_i = 32'd3; rt_val_i = 32'd5;
        @(negedge clk);
        mthi_i = 1'b0; start_i = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy_o) cnt++;
            @(negedge clk);
        end
        chk("mv_start_busy", cnt, 0);
        chk("mv_start_hi", hi_o, 64'h33);
        chk("mv_start_lo", lo_o, 64'h22);

        // T5 second start and mthi while busy are ignored
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b1, lat, nb, dz, mh);
        chk("t5_lat", lat, 35);
        chk("t5_mid_hi", mh, 64'h33);
        chk("t5_lo", lo_o, 64'd14);
        chk("t5_hi", hi_o, 64'd2);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_o) cnt++;
        end
        chk("t5_no_queue", cnt, 0);

        // T6 async reset at cycle 20 of a MULT
        op_i = OP_MULT; rs_val_i = 32'hFFFF_FFFD; rt_val_i = 32'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        chk("t6_busy_before", busy_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_hi_async", hi_o, 0);
        chk("t6_lo_async", lo_o, 0);
        chk("t6_busy_async", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) cnt++;
            @(negedge clk);
        end
        chk("t6_no_done", cnt, 0);
        do_op(OP_MULTU, 32'd3, 32'd5, 1'b0, lat, nb, dz, mh);
        chk("t6_lat", lat, 35);
        chk("t6_lo", lo_o, 64'd15);
        chk("t6_hi", hi_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
